// File: rtl/dw_fp_exp2_pkg.sv
// Shared constants for the DW_fp_exp2 result stage: status bit positions and the exception mask.
package dw_fp_exp2_pkg;

    localparam int ST_ZERO     = 0;
    localparam int ST_INF      = 1;
    localparam int ST_INVALID  = 2;
    localparam int ST_TINY     = 3;
    localparam int ST_HUGE     = 4;
    localparam int ST_INEXACT  = 5;
    localparam int ST_HUGEINT  = 6;
    localparam int ST_COMPSPEC = 7;

    localparam logic [7:0] EXC_MASK = 8'h16;

    function automatic logic is_exc(input logic [7:0] status);
        return |(status & EXC_MASK);
    endfunction

endpackage

// File: rtl/dw_skid_buf2.sv
// Generic two-entry valid/ready skid buffer; in_ready is registered so it never
// depends combinationally on out_ready.
module dw_skid_buf2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_valid, main_valid_n;
    logic             skid_valid, skid_valid_n;
    logic [WIDTH-1:0] main_data, main_data_n;
    logic [WIDTH-1:0] skid_data, skid_data_n;
    logic             ready_q;
    logic             push, pop;

    assign push      = in_valid && ready_q;
    assign pop       = main_valid && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;

    // Main always fills first, so skid is only ever occupied behind a valid main.
    always_comb begin
        main_valid_n = main_valid;
        skid_valid_n = skid_valid;
        main_data_n  = main_data;
        skid_data_n  = skid_data;
        if (!main_valid) begin
            if (push) begin
                main_valid_n = 1'b1;
                main_data_n  = in_data;
            end
        end else if (pop) begin
            if (skid_valid) begin
                main_data_n  = skid_data;
                skid_valid_n = 1'b0;
            end else if (push) begin
                main_data_n  = in_data;
            end else begin
                main_valid_n = 1'b0;
            end
        end else if (push) begin
            skid_valid_n = 1'b1;
            skid_data_n  = in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_data  <= '0;
            skid_data  <= '0;
            ready_q    <= 1'b0;
        end else begin
            main_valid <= main_valid_n;
            skid_valid <= skid_valid_n;
            main_data  <= main_data_n;
            skid_data  <= skid_data_n;
            ready_q    <= !skid_valid_n;
        end
    end

endmodule

// File: rtl/dw_fp_exp2_result_stage.sv
// Registered output stage for DW_fp_exp2: optional tiny flush, skid buffering,
// sticky status flags and a saturating exception counter.
module dw_fp_exp2_result_stage
    import dw_fp_exp2_pkg::*;
#(
    parameter int SIG_WIDTH  = 10,
    parameter int EXP_WIDTH  = 5,
    parameter int FLUSH_TINY = 0,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [SIG_WIDTH+EXP_WIDTH:0]   z_in,
    input  logic [7:0]                     status_in,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [SIG_WIDTH+EXP_WIDTH:0]   z_out,
    output logic [7:0]                     status_out,
    input  logic                           sticky_clr,
    output logic [7:0]                     sticky_flags,
    output logic [CNT_WIDTH-1:0]           exc_count
);

    localparam int ZW = SIG_WIDTH + EXP_WIDTH + 1;
    localparam int BW = ZW + 8;

    logic                 flush;
    logic [ZW-1:0]        z_cap;
    logic [7:0]           status_cap;
    logic [BW-1:0]        buf_out;
    logic                 xfer;
    logic [CNT_WIDTH-1:0] cnt_base;
    logic                 cnt_inc;

    assign flush      = (FLUSH_TINY != 0) && status_in[ST_TINY];
    assign z_cap      = flush ? '0 : z_in;
    assign status_cap = flush ? (status_in | 8'h01) : status_in;

    dw_skid_buf2 #(.WIDTH(BW)) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  ({status_cap, z_cap}),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (buf_out)
    );

    assign z_out      = buf_out[ZW-1:0];
    assign status_out = buf_out[BW-1:ZW];
    assign xfer       = out_valid && out_ready;

    // A clear coinciding with a transfer wipes history first, then applies this transfer.
    assign cnt_base = sticky_clr ? '0 : exc_count;
    assign cnt_inc  = is_exc(status_out) && !(&cnt_base);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_flags <= 8'h00;
            exc_count    <= '0;
        end else if (xfer) begin
            sticky_flags <= (sticky_clr ? 8'h00 : sticky_flags) | status_out;
            exc_count    <= cnt_base + {{(CNT_WIDTH-1){1'b0}}, cnt_inc};
        end else if (sticky_clr) begin
            sticky_flags <= 8'h00;
            exc_count    <= '0;
        end
    end

endmodule

// File: tb/tb_dw_fp_exp2_result_stage.sv
// Bench for dw_fp_exp2_result_stage: two instances (flush off / on) driven in lockstep
// and compared every cycle against a queue-based reference model.
module tb_dw_fp_exp2_result_stage;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b1;
    logic        sticky_clr = 1'b0;
    logic [15:0] z_in = 16'h0;
    logic [7:0]  status_in = 8'h0;

    logic        in_ready0, in_ready1, out_valid0, out_valid1;
    logic [15:0] z_out0, z_out1, cnt0, cnt1;
    logic [7:0]  st_out0, st_out1, flags0, flags1;

    always #5 clk = ~clk;

    dw_fp_exp2_result_stage #(.SIG_WIDTH(10), .EXP_WIDTH(5), .FLUSH_TINY(0), .CNT_WIDTH(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .z_in(z_in), .status_in(status_in), .out_valid(out_valid0), .out_ready(out_ready),
        .z_out(z_out0), .status_out(st_out0), .sticky_clr(sticky_clr),
        .sticky_flags(flags0), .exc_count(cnt0));

    dw_fp_exp2_result_stage #(.SIG_WIDTH(10), .EXP_WIDTH(5), .FLUSH_TINY(1), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .z_in(z_in), .status_in(status_in), .out_valid(out_valid1), .out_ready(out_ready),
        .z_out(z_out1), .status_out(st_out1), .sticky_clr(sticky_clr),
        .sticky_flags(flags1), .exc_count(cnt1));

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: raw accepted {status, z} in order, plus per-instance flags/count.
    logic [23:0] q[$];
    logic [7:0]  m_flags[2];
    int          m_cnt[2];

    function automatic logic [23:0] flushed(input logic [23:0] r, input int f);
        if (f != 0 && r[19]) return {r[23:16] | 8'h01, 16'h0000};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input int d, input logic ir, input logic ov, input logic [15:0] z,
                             input logic [7:0] st, input logic [7:0] fl, input logic [15:0] c);
        logic [23:0] e;
        chk($sformatf("in_ready%0d", d), {31'b0, ir}, {31'b0, q.size() < 2});
        chk($sformatf("out_valid%0d", d), {31'b0, ov}, {31'b0, q.size() > 0});
        if (q.size() > 0) begin
            e = flushed(q[0], d);
            chk($sformatf("z_out%0d", d), {16'b0, z}, {16'b0, e[15:0]});
            chk($sformatf("status_out%0d", d), {24'b0, st}, {24'b0, e[23:16]});
        end
        chk($sformatf("flags%0d", d), {24'b0, fl}, {24'b0, m_flags[d]});
        chk($sformatf("exc_count%0d", d), {16'b0, c}, m_cnt[d]);
    endtask

    task automatic model_reset();
        q.delete();
        for (int d = 0; d < 2; d++) begin
            m_flags[d] = 8'h00;
            m_cnt[d]   = 0;
        end
    endtask

    // One clock: update the model with the inputs present at the edge, check at negedge.
    task automatic step();
        logic        pop, push;
        logic [23:0] r, e;
        @(posedge clk);
        pop  = (q.size() > 0) && out_ready;
        push = in_valid && (q.size() < 2);
        if (pop) begin
            r = q.pop_front();
            for (int d = 0; d < 2; d++) begin
                e = flushed(r, d);
                if (sticky_clr) begin
                    m_flags[d] = 8'h00;
                    m_cnt[d]   = 0;
                end
                m_flags[d] = m_flags[d] | e[23:16];
                if ((e[23:16] & 8'h16) != 0 && m_cnt[d] < 65535) m_cnt[d]++;
            end
        end else if (sticky_clr) begin
            model_reset_flags();
        end
        if (push) q.push_back({status_in, z_in});
        @(negedge clk);
        check_dut(0, in_ready0, out_valid0, z_out0, st_out0, flags0, cnt0);
        check_dut(1, in_ready1, out_valid1, z_out1, st_out1, flags1, cnt1);
    endtask

    task automatic model_reset_flags();
        for (int d = 0; d < 2; d++) begin
            m_flags[d] = 8'h00;
            m_cnt[d]   = 0;
        end
    endtask

    // Present one result and hold it until the model says it was taken.
    task automatic send(input logic [15:0] z, input logic [7:0] st);
        logic taken;
        in_valid  = 1'b1;
        z_in      = z;
        status_in = st;
        taken     = 1'b0;
        for (int i = 0; i < 20 && !taken; i++) begin
            taken = (q.size() < 2);
            step();
        end
        if (!taken) chk("send_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        model_reset();
        #2;
        chk("rst_out_valid", {31'b0, out_valid0}, 32'd0);
        chk("rst_z_out", {16'b0, z_out1}, 32'd0);
        chk("rst_flags", {24'b0, flags0}, 32'd0);
        chk("rst_cnt", {16'b0, cnt1}, 32'd0);
        #10 rst_n = 1'b1;
        idle(1);

        // Pass-through
        send(16'h4000, 8'h00);
        chk("pass_z", {16'b0, z_out0}, 32'h4000);
        chk("pass_valid", {31'b0, out_valid0}, 32'd1);
        chk("pass_cnt", {16'b0, cnt0}, 32'd0);
        idle(2);

        // Backpressure
        out_ready = 1'b0;
        send(16'h3C00, 8'h00);
        send(16'h4400, 8'h00);
        chk("bp_in_ready", {31'b0, in_ready0}, 32'd0);
        in_valid  = 1'b1;
        z_in      = 16'h4800;
        status_in = 8'h00;
        idle(3);
        chk("bp_hold_A", {16'b0, z_out0}, 32'h3C00);
        out_ready = 1'b1;
        idle(1);
        chk("bp_B", {16'b0, z_out0}, 32'h4400);
        idle(1);
        chk("bp_C", {16'b0, z_out0}, 32'h4800);
        in_valid = 1'b0;
        idle(2);

        // Flush
        send(16'h0001, 8'h28);
        chk("flush_z1", {16'b0, z_out1}, 32'h0000);
        chk("flush_st1", {24'b0, st_out1}, 32'h29);
        chk("noflush_z0", {16'b0, z_out0}, 32'h0001);
        chk("noflush_st0", {24'b0, st_out0}, 32'h28);
        idle(1);

        // Sticky flags and counter
        sticky_clr = 1'b1; idle(1); sticky_clr = 1'b0;
        send(16'h1111, 8'h12);
        send(16'h2222, 8'h00);
        send(16'h3333, 8'h04);
        idle(1);
        chk("sticky_flags", {24'b0, flags0}, 32'h16);
        chk("sticky_cnt", {16'b0, cnt0}, 32'd2);
        send(16'h4444, 8'h20);
        sticky_clr = 1'b1; idle(1); sticky_clr = 1'b0;
        chk("clr_flags", {24'b0, flags0}, 32'h20);
        chk("clr_cnt", {16'b0, cnt0}, 32'd0);

        // Saturation
        sticky_clr = 1'b1; idle(1); sticky_clr = 1'b0;
        in_valid  = 1'b1;
        status_in = 8'h02;
        for (int i = 0; i < 65534 + 3; i++) begin
            z_in = i[15:0];
            step();
        end
        in_valid = 1'b0;
        idle(2);
        chk("sat_cnt", {16'b0, cnt0}, 32'hFFFF);
        send(16'h0, 8'h02);
        idle(1);
        chk("sat_hold", {16'b0, cnt1}, 32'hFFFF);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid   = ($urandom_range(1, 0) == 1);
            out_ready  = ($urandom_range(9, 0) < 7);
            sticky_clr = ($urandom_range(19, 0) == 0);
            z_in       = 16'($urandom);
            status_in  = 8'($urandom);
            step();
        end
        in_valid   = 1'b0;
        sticky_clr = 1'b0;
        out_ready  = 1'b1;
        idle(3);

        // Reset mid-stream with both entries full
        out_ready = 1'b0;
        send(16'hAAAA, 8'h12);
        send(16'hBBBB, 8'h04);
        chk("mid_full", {31'b0, in_ready0}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("mid_rst_valid0", {31'b0, out_valid0}, 32'd0);
        chk("mid_rst_valid1", {31'b0, out_valid1}, 32'd0);
        chk("mid_rst_z", {16'b0, z_out0}, 32'd0);
        chk("mid_rst_flags", {24'b0, flags1}, 32'd0);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(1);
        chk("post_rst_ready", {31'b0, in_ready0}, 32'd1);
        idle(3);
        send(16'h5555, 8'h00);
        chk("post_rst_z", {16'b0, z_out0}, 32'h5555);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
